// File: rtl/fetch_queue_nway.sv
// N-way fetch unit: fetches aligned WAYS-instruction groups into a circular {pc,instr}
// queue and presents up to WAYS of the oldest entries to decode each cycle.
module fetch_queue_nway #(
  parameter int unsigned     WAYS     = 2,
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            redirect,
  input  logic [XLEN-1:0]                 redirect_pc,
  output logic                            imem_req,
  output logic [XLEN-1:0]                 imem_addr,
  input  logic                            imem_rvalid,
  input  logic [WAYS*XLEN-1:0]            imem_rdata,
  output logic [WAYS-1:0]                 dec_valid,
  output logic [WAYS*XLEN-1:0]            dec_pc,
  output logic [WAYS*XLEN-1:0]            dec_instr,
  input  logic [$clog2(WAYS+1)-1:0]       dec_take,
  output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);

  localparam int unsigned     GB      = WAYS * 4;
  localparam int unsigned     PTR_W   = $clog2(FQ_DEPTH);
  localparam int unsigned     CNT_W   = $clog2(FQ_DEPTH + 1);
  localparam logic [XLEN-1:0] GB_MASK = XLEN'(GB - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [XLEN-1:0]   slot_pc_q    [FQ_DEPTH];
  logic [XLEN-1:0]   slot_instr_q [FQ_DEPTH];

  logic [XLEN-1:0]   group_addr;
  logic [CNT_W-1:0]  off;
  logic [CNT_W-1:0]  free_slots;
  logic [CNT_W-1:0]  take_ext;
  logic [CNT_W-1:0]  taken;
  logic [CNT_W-1:0]  enq_n;
  logic              enq;
  logic [XLEN-1:0]   lane_pc [WAYS];
  logic [WAYS-1:0]   wr_en;
  logic [PTR_W-1:0]  wr_idx  [WAYS];
  logic [PTR_W-1:0]  rd_idx  [WAYS];

  assign group_addr = pc_q & ~GB_MASK;
  assign off        = CNT_W'((pc_q & GB_MASK) >> 2);
  assign free_slots = CNT_W'(FQ_DEPTH) - count_q;
  assign take_ext   = CNT_W'(dec_take);
  assign enq        = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign enq_n      = enq ? (CNT_W'(WAYS) - off) : '0;
  assign imem_addr  = group_addr;
  assign fq_count   = count_q;

  // A redirect owns the cycle: decode consumption is ignored while the queue flushes.
  always_comb begin
    taken = '0;
    if (!redirect) taken = (take_ext < count_q) ? take_ext : count_q;
  end

  // Free space is reserved at request time, so the response always fits.
  assign imem_req = (state_q == S_IDLE) && !redirect && !rst &&
                    (free_slots >= CNT_W'(WAYS));

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      lane_pc[i] = group_addr + XLEN'(4 * i);
      wr_en[i]   = enq && (CNT_W'(i) >= off);
      wr_idx[i]  = tail_q + PTR_W'(CNT_W'(i) - off);
      rd_idx[i]  = head_q + PTR_W'(i);
      dec_valid[i]                = CNT_W'(i) < count_q;
      dec_pc[i*XLEN +: XLEN]      = slot_pc_q[rd_idx[i]];
      dec_instr[i*XLEN +: XLEN]   = slot_instr_q[rd_idx[i]];
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q + PTR_W'(taken);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + enq_n - taken;
    if (enq) pc_d = group_addr + XLEN'(GB);

    unique case (state_q)
      S_IDLE: if (imem_req) state_d = S_WAIT;
      S_WAIT: begin
        if (redirect)         state_d = imem_rvalid ? S_IDLE : S_DROP;
        else if (imem_rvalid) state_d = S_IDLE;
      end
      S_DROP: if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
      pc_d    = redirect_pc & ~XLEN'(3);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: queue storage is not reset; head/tail/count alone define which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WAYS; i++) begin
      if (wr_en[i]) begin
        slot_pc_q[wr_idx[i]]    <= lane_pc[i];
        slot_instr_q[wr_idx[i]] <= imem_rdata[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_nway.sv
// Directed bench for fetch_queue_nway (WAYS=2, FQ_DEPTH=8) with a latency-programmable
// instruction memory responder; instruction word = address ^ 32'hC0DE0000.
module tb_fetch_queue_nway;

  localparam int unsigned WAYS     = 2;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 8;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic [1:0]  dec_valid;
  logic [63:0] dec_pc;
  logic [63:0] dec_instr;
  logic [1:0]  dec_take = '0;
  logic [3:0]  fq_count;

  int checks = 0;
  int errors = 0;

  bit          pend = 1'b0;
  logic [31:0] paddr = '0;
  int          wait_cnt = 0;
  int          mem_lat = 1;

  fetch_queue_nway #(
    .WAYS(WAYS), .XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_instr(dec_instr), .dec_take(dec_take), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: requests are accepted at the rising edge; the response is
  // presented mem_lat cycles after the request cycle.
  always @(posedge clk) begin
    if (imem_rvalid) pend = 1'b0;
    if (pend && wait_cnt > 0) wait_cnt = wait_cnt - 1;
    if (imem_req) begin
      pend     = 1'b1;
      paddr    = imem_addr;
      wait_cnt = mem_lat - 1;
    end
  end

  always @(negedge clk) begin
    imem_rvalid = pend && (wait_cnt == 0);
    for (int i = 0; i < 2; i++) imem_rdata[i*32 +: 32] = instr_of(paddr + 32'(4 * i));
  end

  // Each cycle's activity happens at negedge+1: drive inputs, then sample.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Holds reset long enough for any outstanding response to drain, then releases;
  // returns in cycle 0 after release.
  task automatic do_reset();
    cyc();
    rst = 1'b1; redirect = 1'b0; dec_take = '0; redirect_pc = '0;
    repeat (4) cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (fq_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fq_count); end
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL reset_dec_valid: got %b exp 00", dec_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    mem_lat = 1;
    do_reset();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_first_addr: got %h exp %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] base;
    mem_lat = 1;
    do_reset();
    dec_take = 2'd2;
    #1;
    for (int k = 0; k < 4; k++) begin
      base = RESET_PC + 32'(8 * k);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req%0d: got %b exp 1", k, imem_req); end
      checks++; if (imem_addr !== base) begin errors++; $display("FAIL stream_addr%0d: got %h exp %h", k, imem_addr, base); end
      if (k > 0) begin
        checks++; if (dec_valid !== 2'b11) begin errors++; $display("FAIL stream_valid%0d: got %b exp 11", k, dec_valid); end
        checks++; if (dec_pc !== {base - 32'd4, base - 32'd8}) begin errors++; $display("FAIL stream_pc%0d: got %h exp %h", k, dec_pc, {base - 32'd4, base - 32'd8}); end
        checks++; if (dec_instr !== {instr_of(base - 32'd4), instr_of(base - 32'd8)}) begin errors++; $display("FAIL stream_instr%0d: got %h", k, dec_instr); end
      end
      cyc();
      checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL stream_drain%0d: got %b exp 00", k, dec_valid); end
      cyc();
    end
  endtask

  task automatic test_full();
    mem_lat = 1;
    do_reset();
    repeat (8) cyc();
    checks++; if (fq_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d exp 8", fq_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b exp 0", imem_req); end
    checks++; if (dec_pc[31:0] !== RESET_PC) begin errors++; $display("FAIL full_head_pc: got %h exp %h", dec_pc[31:0], RESET_PC); end
    dec_take = 2'd1;
    cyc();
    checks++; if (fq_count !== 4'd7) begin errors++; $display("FAIL full_take1_count: got %0d exp 7", fq_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_free1_req: got %b exp 0", imem_req); end
    checks++; if (dec_pc[31:0] !== RESET_PC + 32'd4) begin errors++; $display("FAIL full_take1_pc: got %h exp %h", dec_pc[31:0], RESET_PC + 32'd4); end
    cyc();
    dec_take = 2'd0;
    #1;
    checks++; if (fq_count !== 4'd6) begin errors++; $display("FAIL full_take2_count: got %0d exp 6", fq_count); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL full_resume_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC + 32'h20) begin errors++; $display("FAIL full_resume_addr: got %h exp %h", imem_addr, RESET_PC + 32'h20); end
  endtask

  task automatic test_redirect_idle();
    mem_lat = 1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0040_0107;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdi_req_blocked: got %b exp 0", imem_req); end
    cyc();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rdi_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL rdi_addr: got %h exp 00400100", imem_addr); end
    cyc(); cyc();
    checks++; if (fq_count !== 4'd1) begin errors++; $display("FAIL rdi_count: got %0d exp 1", fq_count); end
    checks++; if (dec_valid !== 2'b01) begin errors++; $display("FAIL rdi_valid: got %b exp 01", dec_valid); end
    checks++; if (dec_pc[31:0] !== 32'h0040_0104) begin errors++; $display("FAIL rdi_pc: got %h exp 00400104", dec_pc[31:0]); end
    checks++; if (dec_instr[31:0] !== instr_of(32'h0040_0104)) begin errors++; $display("FAIL rdi_instr: got %h exp %h", dec_instr[31:0], instr_of(32'h0040_0104)); end
    checks++; if (imem_addr !== 32'h0040_0108) begin errors++; $display("FAIL rdi_next_addr: got %h exp 00400108", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    do_reset();
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0040_0200;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_wait: got %b exp 0", imem_req); end
    cyc();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_drop: got %b exp 0", imem_req); end
    cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_drop_rv: got %b exp 0", imem_req); end
    cyc();
    checks++; if (fq_count !== 4'd0) begin errors++; $display("FAIL rdw_count: got %0d exp 0", fq_count); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rdw_req_idle: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL rdw_addr: got %h exp 00400200", imem_addr); end
    repeat (4) cyc();
    checks++; if (dec_valid !== 2'b11) begin errors++; $display("FAIL rdw_valid: got %b exp 11", dec_valid); end
    checks++; if (dec_pc !== 64'h0040_0204_0040_0200) begin errors++; $display("FAIL rdw_pc: got %h exp 0040020400400200", dec_pc); end
  endtask

  task automatic test_redirect_rvalid();
    mem_lat = 1;
    do_reset();
    cyc(); cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'h0040_0300; dec_take = 2'd2;
    #1;
    checks++; if (fq_count !== 4'd2) begin errors++; $display("FAIL rdr_pre_count: got %0d exp 2", fq_count); end
    checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rdr_align: got rvalid %b exp 1", imem_rvalid); end
    cyc();
    redirect = 1'b0; dec_take = 2'd0;
    #1;
    checks++; if (fq_count !== 4'd0) begin errors++; $display("FAIL rdr_count: got %0d exp 0", fq_count); end
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL rdr_valid: got %b exp 00", dec_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rdr_idle_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0300) begin errors++; $display("FAIL rdr_addr: got %h exp 00400300", imem_addr); end
    cyc(); cyc();
    checks++; if (fq_count !== 4'd2) begin errors++; $display("FAIL rdr_refill: got %0d exp 2", fq_count); end
    checks++; if (dec_pc[31:0] !== 32'h0040_0300) begin errors++; $display("FAIL rdr_pc: got %h exp 00400300", dec_pc[31:0]); end
  endtask

  task automatic test_wrap_and_reset();
    int          model_cnt;
    int          consumed;
    int          cyc_n;
    int          tk;
    int          taken;
    int          n;
    logic [31:0] exp_pc;
    logic [1:0]  exp_dv;
    mem_lat = 1;
    do_reset();
    model_cnt = 0; consumed = 0; cyc_n = 0; exp_pc = RESET_PC;
    while (consumed < 40 && cyc_n < 400) begin
      tk = (cyc_n % 2 == 0) ? 1 : 2;
      dec_take = 2'(tk);
      #1;
      exp_dv = (model_cnt >= 2) ? 2'b11 : ((model_cnt == 1) ? 2'b01 : 2'b00);
      checks++; if (fq_count !== 4'(model_cnt)) begin errors++; $display("FAIL wrap_count c%0d: got %0d exp %0d", cyc_n, fq_count, model_cnt); end
      checks++; if (dec_valid !== exp_dv) begin errors++; $display("FAIL wrap_valid c%0d: got %b exp %b", cyc_n, dec_valid, exp_dv); end
      for (int i = 0; i < 2; i++) begin
        if (i < model_cnt) begin
          checks++; if (dec_pc[i*32 +: 32] !== exp_pc + 32'(4 * i)) begin errors++; $display("FAIL wrap_pc c%0d l%0d: got %h exp %h", cyc_n, i, dec_pc[i*32 +: 32], exp_pc + 32'(4 * i)); end
          checks++; if (dec_instr[i*32 +: 32] !== instr_of(exp_pc + 32'(4 * i))) begin errors++; $display("FAIL wrap_instr c%0d l%0d: got %h", cyc_n, i, dec_instr[i*32 +: 32]); end
        end
      end
      taken = (tk < model_cnt) ? tk : model_cnt;
      consumed += taken;
      exp_pc += 32'(4 * taken);
      model_cnt = model_cnt - taken + (imem_rvalid ? 2 : 0);
      cyc();
      cyc_n++;
    end
    checks++; if (consumed < 40) begin errors++; $display("FAIL wrap_timeout: got %0d consumed exp 40", consumed); end

    dec_take = '0;
    mem_lat = 3;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin cyc(); n++; end
    checks++; if (n >= 10) begin errors++; $display("FAIL midwait_no_req: got no request in %0d cycles", n); end
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (fq_count !== 4'd0) begin errors++; $display("FAIL midwait_count: got %0d exp 0", fq_count); end
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL midwait_valid: got %b exp 00", dec_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midwait_req: got %b exp 0", imem_req); end
    cyc(); cyc();
    checks++; if (fq_count !== 4'd0) begin errors++; $display("FAIL late_rvalid_count: got %0d exp 0", fq_count); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL post_reset_addr: got %h exp %h", imem_addr, RESET_PC); end
    checks++; if (fq_count !== 4'd0) begin errors++; $display("FAIL post_reset_count: got %0d exp 0", fq_count); end
    repeat (4) cyc();
    checks++; if (fq_count !== 4'd2) begin errors++; $display("FAIL post_reset_fill: got %0d exp 2", fq_count); end
    checks++; if (dec_pc[31:0] !== RESET_PC) begin errors++; $display("FAIL post_reset_pc: got %h exp %h", dec_pc[31:0], RESET_PC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
